regfile_scoreboard: RTL and testbench

// - Parametrised multi-port register file for the next CPU datapath generation.
// - Adds configurable width, depth and read-port count, async reset, and a busy-bit scoreboard.
// - The scoreboard tracks registers with an outstanding write (issued, not yet written back), so decode can detect RAW hazards.
// - Sits between decode (read/issue) and writeback; replaces the single-write/two-read negedge register file.

---
 rtl/regfile_scoreboard.sv | 99 +++++++++
 tb/tb_regfile_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Parametrised multi-port register file with a busy-bit scoreboard for RAW hazard detection.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to matching reads.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
  logic [ADDR_W:0]          busy_cnt_q, busy_cnt_d;
  logic                     wb_ok, issue_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign wb_ok    = wb_en    && !is_zero(wb_addr);
  assign issue_ok = issue_en && !is_zero(issue_addr);

  // Issue is applied after writeback so a same-cycle new producer keeps the register busy.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    busy_d = busy_q;
    if (wb_ok)    busy_d[wb_addr]    = 1'b0;
    if (issue_ok) busy_d[issue_addr] = 1'b1;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] addr;
    addr      = '0;
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      addr = rd_addr[p*ADDR_W +: ADDR_W];
      rd_data_d[p*DATA_W +: DATA_W] = regs_q[addr];
      rd_busy_d[p]                  = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (wb_ok && (wb_addr == addr)) begin
        rd_data_d[p*DATA_W +: DATA_W] = wb_data;
        rd_busy_d[p]                  = busy_d[addr];
      end
`endif
      if (is_zero(addr)) begin
        rd_data_d[p*DATA_W +: DATA_W] = '0;
        rd_busy_d[p]                  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register array is reset because reads after reset must return 0, not X.
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
      busy_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every read in this block seeing pre-edge state.
      if (wb_ok) regs_q[wb_addr] <= wb_data;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_busy_q  <= rd_busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_busy  = rd_busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; a second instance uses ZERO_REG=0.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rd_addr;
  logic [63:0] rd_data, rd_data_z;
  logic [1:0]  rd_busy, rd_busy_z;
  logic        issue_en;
  logic [5:0]  issue_addr;
  logic        wb_en;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic [6:0]  busy_cnt, busy_cnt_z;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(6), .NUM_RD(2), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_en(issue_en), .issue_addr(issue_addr), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy_cnt(busy_cnt)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(6), .NUM_RD(2), .ZERO_REG(0)) u_dut_z0 (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
    .issue_en(issue_en), .issue_addr(issue_addr), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy_cnt(busy_cnt_z)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0;
    wb_en    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_addr = '0; issue_en = 1'b1; issue_addr = 6'd7;
    wb_en = 1'b0; wb_addr = 6'd5; wb_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      wb_en = ~wb_en;
      tick();
    end
    n_total++; if (rd_data !== 64'd0) $display("FAIL reset_rd_data: got %h want %h", rd_data, 64'd0); else n_pass++;
    n_total++; if (rd_busy !== 2'b00) $display("FAIL reset_rd_busy: got %b want %b", rd_busy, 2'b00); else n_pass++;
    n_total++; if (busy_cnt !== 7'd0) $display("FAIL reset_busy_cnt: got %0d want %0d", busy_cnt, 0); else n_pass++;
    rst_n = 1'b1;
    idle();
    rd_addr[5:0] = 6'd5;
    tick();
    n_total++; if (rd_data[31:0] !== 32'd0) $display("FAIL reset_read_x5: got %h want %h", rd_data[31:0], 32'd0); else n_pass++;
    n_total++; if (busy_cnt !== 7'd0) $display("FAIL reset_release_cnt: got %0d want %0d", busy_cnt, 0); else n_pass++;
  endtask

  task automatic test_write_read();
    wb_en = 1'b1; wb_addr = 6'd5; wb_data = 32'hDEAD_BEEF;
    tick();
    idle();
    rd_addr[5:0] = 6'd5; rd_addr[11:6] = 6'd5;
    tick();
    n_total++; if (rd_data[63:32] !== 32'hDEAD_BEEF) $display("FAIL wr_rd_port1: got %h want %h", rd_data[63:32], 32'hDEAD_BEEF); else n_pass++;
    n_total++; if (rd_data[31:0] !== 32'hDEAD_BEEF) $display("FAIL wr_rd_port0_same_addr: got %h want %h", rd_data[31:0], 32'hDEAD_BEEF); else n_pass++;
    n_total++; if (rd_busy !== 2'b00) $display("FAIL wr_rd_busy: got %b want %b", rd_busy, 2'b00); else n_pass++;
  endtask

  task automatic test_scoreboard();
    rd_addr[5:0] = 6'd9;
    issue_en = 1'b1; issue_addr = 6'd9;
    tick();
    idle();
    n_total++; if (busy_cnt !== 7'd1) $display("FAIL sb_issue_cnt: got %0d want %0d", busy_cnt, 1); else n_pass++;
    tick();
    n_total++; if (rd_busy[0] !== 1'b1) $display("FAIL sb_read_busy: got %b want %b", rd_busy[0], 1'b1); else n_pass++;
    wb_en = 1'b1; wb_addr = 6'd9; wb_data = 32'd7;
    tick();
    idle();
    n_total++; if (busy_cnt !== 7'd0) $display("FAIL sb_wb_cnt: got %0d want %0d", busy_cnt, 0); else n_pass++;
    tick();
    n_total++; if (rd_data[31:0] !== 32'd7) $display("FAIL sb_wb_data: got %h want %h", rd_data[31:0], 32'd7); else n_pass++;
    n_total++; if (rd_busy[0] !== 1'b0) $display("FAIL sb_wb_busy: got %b want %b", rd_busy[0], 1'b0); else n_pass++;
  endtask

  task automatic test_collision();
    issue_en = 1'b1; issue_addr = 6'd4;
    tick();
    tick();
    n_total++; if (busy_cnt !== 7'd1) $display("FAIL col_double_issue_cnt: got %0d want %0d", busy_cnt, 1); else n_pass++;
    wb_en = 1'b1; wb_addr = 6'd4; wb_data = 32'd3;
    tick();
    idle();
    n_total++; if (busy_cnt !== 7'd1) $display("FAIL col_same_edge_cnt: got %0d want %0d", busy_cnt, 1); else n_pass++;
    rd_addr[11:6] = 6'd4;
    tick();
    n_total++; if (rd_data[63:32] !== 32'd3) $display("FAIL col_data: got %h want %h", rd_data[63:32], 32'd3); else n_pass++;
    n_total++; if (rd_busy[1] !== 1'b1) $display("FAIL col_busy: got %b want %b", rd_busy[1], 1'b1); else n_pass++;
    wb_en = 1'b1; wb_addr = 6'd4; wb_data = 32'd8;
    tick();
    n_total++; if (busy_cnt !== 7'd0) $display("FAIL col_clear_cnt: got %0d want %0d", busy_cnt, 0); else n_pass++;
    wb_data = 32'd9;
    tick();
    idle();
    n_total++; if (busy_cnt !== 7'd0) $display("FAIL nonbusy_wb_cnt: got %0d want %0d", busy_cnt, 0); else n_pass++;
    tick();
    n_total++; if (rd_data[63:32] !== 32'd9) $display("FAIL nonbusy_wb_data: got %h want %h", rd_data[63:32], 32'd9); else n_pass++;
    n_total++; if (rd_busy[1] !== 1'b0) $display("FAIL nonbusy_wb_busy: got %b want %b", rd_busy[1], 1'b0); else n_pass++;
    issue_en = 1'b1; issue_addr = 6'd10; wb_en = 1'b1; wb_addr = 6'd11; wb_data = 32'd5;
    tick();
    idle();
    n_total++; if (busy_cnt !== 7'd1) $display("FAIL diff_addr_cnt: got %0d want %0d", busy_cnt, 1); else n_pass++;
    rd_addr[5:0] = 6'd11; rd_addr[11:6] = 6'd10;
    tick();
    n_total++; if (rd_data[31:0] !== 32'd5) $display("FAIL diff_addr_data: got %h want %h", rd_data[31:0], 32'd5); else n_pass++;
    n_total++; if (rd_busy !== 2'b10) $display("FAIL diff_addr_busy: got %b want %b", rd_busy, 2'b10); else n_pass++;
    wb_en = 1'b1; wb_addr = 6'd10; wb_data = 32'd1;
    tick();
    idle();
    n_total++; if (busy_cnt !== 7'd0) $display("FAIL diff_addr_clear_cnt: got %0d want %0d", busy_cnt, 0); else n_pass++;
  endtask

  task automatic test_bypass();
    logic [31:0] exp_d;
    logic        exp_b;
    rd_addr[5:0] = 6'd6;
    wb_en = 1'b1; wb_addr = 6'd6; wb_data = 32'd42;
    tick();
    idle();
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'd42;
`else
    exp_d = 32'd0;
`endif
    n_total++; if (rd_data[31:0] !== exp_d) $display("FAIL bypass_same_cycle: got %h want %h", rd_data[31:0], exp_d); else n_pass++;
    tick();
    n_total++; if (rd_data[31:0] !== 32'd42) $display("FAIL bypass_next_cycle: got %h want %h", rd_data[31:0], 32'd42); else n_pass++;
    issue_en = 1'b1; issue_addr = 6'd6; wb_en = 1'b1; wb_addr = 6'd6; wb_data = 32'd43;
    tick();
    idle();
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'd43; exp_b = 1'b1;
`else
    exp_d = 32'd42; exp_b = 1'b0;
`endif
    n_total++; if (rd_data[31:0] !== exp_d) $display("FAIL bypass_issue_data: got %h want %h", rd_data[31:0], exp_d); else n_pass++;
    n_total++; if (rd_busy[0] !== exp_b) $display("FAIL bypass_issue_busy: got %b want %b", rd_busy[0], exp_b); else n_pass++;
    tick();
    n_total++; if (rd_data[31:0] !== 32'd43 || rd_busy[0] !== 1'b1) $display("FAIL bypass_issue_after: got %h/%b want %h/%b", rd_data[31:0], rd_busy[0], 32'd43, 1'b1); else n_pass++;
    wb_en = 1'b1; wb_addr = 6'd6; wb_data = 32'd44;
    tick();
    idle();
    n_total++; if (busy_cnt !== 7'd0) $display("FAIL bypass_clear_cnt: got %0d want %0d", busy_cnt, 0); else n_pass++;
  endtask

  task automatic test_zero_reg();
    rd_addr[5:0] = 6'd0;
    issue_en = 1'b1; issue_addr = 6'd0; wb_en = 1'b1; wb_addr = 6'd0; wb_data = 32'd99;
    tick();
    idle();
    tick();
    n_total++; if (rd_data[31:0] !== 32'd0) $display("FAIL zero_data: got %h want %h", rd_data[31:0], 32'd0); else n_pass++;
    n_total++; if (rd_busy[0] !== 1'b0) $display("FAIL zero_busy: got %b want %b", rd_busy[0], 1'b0); else n_pass++;
    n_total++; if (busy_cnt !== 7'd0) $display("FAIL zero_cnt: got %0d want %0d", busy_cnt, 0); else n_pass++;
    n_total++; if (rd_data_z[31:0] !== 32'd99) $display("FAIL z0_data: got %h want %h", rd_data_z[31:0], 32'd99); else n_pass++;
    n_total++; if (rd_busy_z[0] !== 1'b1) $display("FAIL z0_busy: got %b want %b", rd_busy_z[0], 1'b1); else n_pass++;
    n_total++; if (busy_cnt_z !== 7'd1) $display("FAIL z0_cnt: got %0d want %0d", busy_cnt_z, 1); else n_pass++;
  endtask

  task automatic test_async_reset();
    issue_en = 1'b1; issue_addr = 6'd12;
    tick();
    idle();
    n_total++; if (busy_cnt !== 7'd1) $display("FAIL ares_pre_cnt: got %0d want %0d", busy_cnt, 1); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (busy_cnt !== 7'd0) $display("FAIL ares_immediate_cnt: got %0d want %0d", busy_cnt, 0); else n_pass++;
    n_total++; if (rd_data_z !== 64'd0) $display("FAIL ares_immediate_data: got %h want %h", rd_data_z, 64'd0); else n_pass++;
    tick();
    rst_n = 1'b1;
    rd_addr[5:0] = 6'd5;
    issue_en = 1'b1; issue_addr = 6'd13;
    tick();
    idle();
    n_total++; if (rd_data[31:0] !== 32'd0) $display("FAIL ares_x5_lost: got %h want %h", rd_data[31:0], 32'd0); else n_pass++;
    n_total++; if (busy_cnt !== 7'd1) $display("FAIL ares_first_edge_cnt: got %0d want %0d", busy_cnt, 1); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_zero_reg();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
